// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall sequencing, branch flush, operand
// forwarding select and saturating stall/flush event counters.
//
// state | meaning
// IDLE  | normal flow; load-use stalls in place, taken branch flushes
// STALL | extra load-use bubbles, rem counts the remaining ones
// FLUSH | second squash cycle after a taken branch
module hazard_control_unit #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned LOAD_STALL   = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic [ADDR_W-1:0] ex_rs1,
    input  logic [ADDR_W-1:0] ex_rs2,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic              branch_taken,
    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic              ctrl_mux_sel,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu;
    logic             unused_ex_reg_write;

    // A load always writes its destination, so ex_mem_read alone qualifies the hazard.
    assign unused_ex_reg_write = ex_reg_write;

    assign lu = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ctrl_mux_sel  = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        case (state_q)
            IDLE, STALL: begin
                if (branch_taken) begin
                    ctrl_mux_sel = 1'b0;
                    ifid_flush   = 1'b1;
                    idex_flush   = 1'b1;
                    if (FLUSH_CYCLES == 2) begin
                        state_d = FLUSH;
                        rem_d   = 2'd1;
                    end else begin
                        state_d = IDLE;
                        rem_d   = 2'd0;
                    end
                end else if (state_q == STALL) begin
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    ctrl_mux_sel  = 1'b0;
                    rem_d         = rem_q - 2'd1;
                    if (rem_q == 2'd1) begin
                        state_d = IDLE;
                    end
                end else if (lu) begin
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    ctrl_mux_sel  = 1'b0;
                    if (LOAD_STALL > 1) begin
                        state_d = STALL;
                        rem_d   = 2'(LOAD_STALL - 1);
                    end
                end
            end
            FLUSH: begin
                ctrl_mux_sel = 1'b0;
                ifid_flush   = 1'b1;
                idex_flush   = 1'b1;
                state_d      = IDLE;
                rem_d        = 2'd0;
            end
            default: begin
                state_d = IDLE;
                rem_d   = 2'd0;
            end
        endcase
    end

    // Register 0 is hard-wired, so it never forwards.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs1)) begin
            fwd_a = 2'b10;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs1)) begin
            fwd_a = 2'b01;
        end
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs2)) begin
            fwd_b = 2'b10;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs2)) begin
            fwd_b = 2'b01;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write_en && !ifid_flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ifid_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rem_q       <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
